spi_flash_read_arbiter: RTL and testbench



---
 rtl/spi_flash_pkg.sv | 27 ++
 rtl/rr_picker.sv | 40 ++++
 rtl/spi_flash_read_arbiter.sv | 169 ++++++++++++++++
 tb/tb_spi_flash_read_arbiter.sv | 413 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_flash_pkg.sv
// Shared definitions for the SPI flash read path: arbiter FSM encoding,
// engine mode codes and the die address limit also used by the read engine.
package spi_flash_pkg;

  // Arbiter FSM states
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY    = 2'd1,
    ST_RELEASE = 2'd2,
    ST_FAULT   = 2'd3
  } state_t;

  // Engine read modes
  localparam logic [1:0] MODE_SINGLE  = 2'd0;
  localparam logic [1:0] MODE_DUAL    = 2'd1;
  localparam logic [1:0] MODE_QUAD    = 2'd2;
  localparam logic [1:0] MODE_ILLEGAL = 2'd3;

  // Last byte address of one flash die
  localparam logic [31:0] FLASH_DIE_LIMIT = 32'h01FF_FFFF;

  // True when the engine can execute the given mode
  function automatic logic mode_is_legal(input logic [1:0] mode);
    return mode != MODE_ILLEGAL;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin priority encoder: first asserted request at or
// after i_rr_ptr, wrapping modulo N_REQ. i_rr_ptr must be below N_REQ.
module rr_picker #(
  parameter int N_REQ = 3,
  parameter int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [IDX_W-1:0] i_rr_ptr,
  output logic             o_valid,
  output logic [IDX_W-1:0] o_idx,
  output logic [N_REQ-1:0] o_onehot
);

  logic [IDX_W:0]   w_sum;
  logic [IDX_W-1:0] w_pos;

  // Scan from the pointer upward; the first hit wins
  always_comb begin
    o_valid  = 1'b0;
    o_idx    = '0;
    o_onehot = '0;
    w_sum    = '0;
    w_pos    = '0;
    for (int k = 0; k < N_REQ; k++) begin
      w_sum = {1'b0, i_rr_ptr} + (IDX_W+1)'(k);
      if (w_sum >= (IDX_W+1)'(N_REQ)) begin
        w_sum = w_sum - (IDX_W+1)'(N_REQ);
      end
      w_pos = w_sum[IDX_W-1:0];
      if (!o_valid && i_req[w_pos]) begin
        o_valid = 1'b1;
        o_idx   = w_pos;
      end
    end
    if (o_valid) begin
      o_onehot[o_idx] = 1'b1;
    end
  end

endmodule

// File: rtl/spi_flash_read_arbiter.sv
// Shares one SPI flash read engine between N_REQ requesters. Round-robin
// arbitration, request validation, transfer timeout with sticky fault.
//
// Handshake: a requester raises req[i] with its start/end/mode slice stable
// and holds it until it sees done[i] or err[i] (one-cycle pulses), then drops
// req[i] in that same cycle. grant[i] is high while the engine works for i.
// The engine sees eng_start_flag high for the whole transfer except in the
// cycle it reports eng_read_finish, so it never re-launches.
module spi_flash_read_arbiter
  import spi_flash_pkg::*;
#(
  parameter int N_REQ          = 3,
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 2**20,
  parameter int TMO_W          = 21
) (
  input  logic                    system_clk,
  input  logic                    system_reset,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*ADDR_W-1:0] req_start_addr,
  input  logic [N_REQ*ADDR_W-1:0] req_end_addr,
  input  logic [N_REQ*2-1:0]      req_mode,
  output logic [N_REQ-1:0]        grant,
  output logic [N_REQ-1:0]        done,
  output logic [N_REQ-1:0]        err,
  output logic                    fault,
  output logic                    eng_start_flag,
  output logic [ADDR_W-1:0]       eng_start_addr,
  output logic [ADDR_W-1:0]       eng_end_addr,
  output logic [1:0]              eng_mode,
  input  logic                    eng_read_finish,
  output state_t                  dbg_state
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  state_t             r_state;
  logic [IDX_W-1:0]   r_rr_ptr;
  logic [IDX_W-1:0]   r_win_idx;
  logic [N_REQ-1:0]   r_grant;
  logic [N_REQ-1:0]   r_done;
  logic [N_REQ-1:0]   r_err;
  logic               r_fault;
  logic [ADDR_W-1:0]  r_eng_start;
  logic [ADDR_W-1:0]  r_eng_end;
  logic [1:0]         r_eng_mode;
  logic [TMO_W-1:0]   r_tmo;

  logic               w_pick_valid;
  logic [IDX_W-1:0]   w_pick_idx;
  logic [N_REQ-1:0]   w_pick_onehot;
  logic [ADDR_W-1:0]  w_sel_start;
  logic [ADDR_W-1:0]  w_sel_end;
  logic [1:0]         w_sel_mode;
  logic               w_sel_bad;
  logic               w_err_busy;

  // Pointer advance past a served or rejected requester
  function automatic logic [IDX_W-1:0] f_next(input logic [IDX_W-1:0] idx);
    if (idx == IDX_W'(N_REQ - 1)) begin
      return '0;
    end
    return idx + 1'b1;
  endfunction

  rr_picker #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr_picker (
    .i_req    (req),
    .i_rr_ptr (r_rr_ptr),
    .o_valid  (w_pick_valid),
    .o_idx    (w_pick_idx),
    .o_onehot (w_pick_onehot)
  );

  // Only the candidate's slice is looked at; other slices may move freely
  assign w_sel_start = req_start_addr[w_pick_idx*ADDR_W +: ADDR_W];
  assign w_sel_end   = req_end_addr[w_pick_idx*ADDR_W +: ADDR_W];
  assign w_sel_mode  = req_mode[w_pick_idx*2 +: 2];
  assign w_sel_bad   = (w_sel_end < w_sel_start) || !mode_is_legal(w_sel_mode);

  // While an err pulse is on the wire the requester has not yet dropped req;
  // skipping arbitration for that cycle avoids rejecting it twice.
  assign w_err_busy  = |r_err;

  // Arbitration FSM, engine parameter registers and timeout counter
  always_ff @(posedge system_clk or posedge system_reset) begin
    if (system_reset) begin
      r_state     <= ST_IDLE;
      r_rr_ptr    <= '0;
      r_win_idx   <= '0;
      r_grant     <= '0;
      r_done      <= '0;
      r_err       <= '0;
      r_fault     <= 1'b0;
      r_eng_start <= '0;
      r_eng_end   <= '0;
      r_eng_mode  <= '0;
      r_tmo       <= '0;
    end else begin
      r_done <= '0;
      r_err  <= '0;
      case (r_state)
        ST_IDLE: begin
          if (r_fault) begin
            r_state <= ST_FAULT;
          end else if (w_pick_valid && !w_err_busy) begin
            r_win_idx   <= w_pick_idx;
            r_eng_start <= w_sel_start;
            r_eng_end   <= w_sel_end;
            r_eng_mode  <= w_sel_mode;
            if (w_sel_bad) begin
              r_err    <= w_pick_onehot;
              r_rr_ptr <= f_next(w_pick_idx);
            end else begin
              r_grant <= w_pick_onehot;
              r_tmo   <= '0;
              r_state <= ST_BUSY;
            end
          end
        end
        ST_BUSY: begin
          r_tmo <= r_tmo + 1'b1;
          if (eng_read_finish) begin
            r_done  <= r_grant;
            r_grant <= '0;
            r_state <= ST_RELEASE;
          end else if (r_tmo == TMO_LAST) begin
            r_err   <= r_grant;
            r_grant <= '0;
            r_fault <= 1'b1;
            r_state <= ST_FAULT;
          end
        end
        ST_RELEASE: begin
          r_grant  <= '0;
          r_rr_ptr <= f_next(r_win_idx);
          r_state  <= ST_IDLE;
        end
        ST_FAULT: begin
          // Engine may still be reading; refuse everyone until reset
          r_grant <= '0;
          if (w_pick_valid && !w_err_busy) begin
            r_err    <= w_pick_onehot;
            r_rr_ptr <= f_next(w_pick_idx);
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Start flag is combinational so it drops in the finish cycle and on reset
  assign eng_start_flag = (r_state == ST_BUSY) && !eng_read_finish;

  assign grant          = r_grant;
  assign done           = r_done;
  assign err            = r_err;
  assign fault          = r_fault;
  assign eng_start_addr = r_eng_start;
  assign eng_end_addr   = r_eng_end;
  assign eng_mode       = r_eng_mode;
  assign dbg_state      = r_state;

endmodule

// File: tb/tb_spi_flash_read_arbiter.sv
// Bench for spi_flash_read_arbiter: requester and engine models, event
// scoreboard (grant/done/err order) and directed timing checks.
module tb_spi_flash_read_arbiter;
  import spi_flash_pkg::*;

  localparam int N  = 3;
  localparam int AW = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT signals ----------------
  logic [N-1:0]    req;
  logic [N*AW-1:0] sa;
  logic [N*AW-1:0] ea;
  logic [N*2-1:0]  md;
  logic [N-1:0]    grant;
  logic [N-1:0]    done;
  logic [N-1:0]    err;
  logic            fault;
  logic            eng_start_flag;
  logic [AW-1:0]   eng_start_addr;
  logic [AW-1:0]   eng_end_addr;
  logic [1:0]      eng_mode;
  logic            eng_read_finish;
  state_t          dbg_state;

  spi_flash_read_arbiter #(
    .N_REQ          (N),
    .ADDR_W         (AW),
    .TIMEOUT_CYCLES (64),
    .TMO_W          (21)
  ) dut (
    .system_clk      (clk),
    .system_reset    (rst),
    .req             (req),
    .req_start_addr  (sa),
    .req_end_addr    (ea),
    .req_mode        (md),
    .grant           (grant),
    .done            (done),
    .err             (err),
    .fault           (fault),
    .eng_start_flag  (eng_start_flag),
    .eng_start_addr  (eng_start_addr),
    .eng_end_addr    (eng_end_addr),
    .eng_mode        (eng_mode),
    .eng_read_finish (eng_read_finish),
    .dbg_state       (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  logic [7:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;
  int want_tok[N];
  int rise_cyc[N];
  int grant_cyc[N];
  int done_cyc[N];
  int err_cyc[N];
  int flag_cnt = 0;
  int eng_lat  = -1;

  localparam int K_GRANT = 1;
  localparam int K_DONE  = 2;
  localparam int K_ERR   = 3;

  function automatic logic [7:0] ev(input int kind, input int idx);
    return 8'((kind << 4) | idx);
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic got_evt(input logic [7:0] e);
    n_tests++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("[TB] FAIL event: got %0h expected none (cycle %0d)", e, cyc);
    end else begin
      logic [7:0] x;
      x = exp_q.pop_front();
      if (x !== e) begin
        n_fail++;
        $display("[TB] FAIL event: got %0h expected %0h (cycle %0d)", e, x, cyc);
      end
    end
  endtask

  // ---------------- requester model (sole driver of req) ----------------
  initial begin : requester
    int seen[N];
    req = '0;
    for (int i = 0; i < N; i++) seen[i] = 0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (rst) begin
          req[i]  = 1'b0;
          seen[i] = want_tok[i];
        end else if (done[i] || err[i]) begin
          req[i] = 1'b0;
        end else if (want_tok[i] != seen[i]) begin
          seen[i]     = want_tok[i];
          req[i]      = 1'b1;
          rise_cyc[i] = cyc;
        end
      end
    end
  end

  // ---------------- engine model ----------------
  initial begin : engine
    int cnt;
    cnt = 0;
    eng_read_finish = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (rst || eng_read_finish) begin
        eng_read_finish = 1'b0;
        cnt = 0;
      end else if (eng_start_flag) begin
        cnt++;
        if (eng_lat >= 0 && cnt >= eng_lat) eng_read_finish = 1'b1;
      end else begin
        cnt = 0;
      end
    end
  end

  // ---------------- monitor ----------------
  initial begin : monitor
    logic [N-1:0] pg;
    int last_low;
    pg = '0;
    last_low = -1;
    forever begin
      @(negedge clk);
      if (rst) begin
        pg = '0;
        last_low = -1;
      end else begin
        for (int i = 0; i < N; i++) begin
          if (grant[i] && !pg[i]) begin
            got_evt(ev(K_GRANT, i));
            grant_cyc[i] = cyc;
            check("flag_with_grant", eng_start_flag, 1);
            if (last_low >= 0) check("grant_gap_ge2", (cyc - last_low) >= 2, 1);
          end
          if (done[i]) begin
            got_evt(ev(K_DONE, i));
            done_cyc[i] = cyc;
          end
          if (err[i]) begin
            got_evt(ev(K_ERR, i));
            err_cyc[i] = cyc;
          end
        end
        if (pg != '0 && grant == '0) last_low = cyc;
        if (eng_read_finish) check("flag_low_on_finish", eng_start_flag, 0);
        if (eng_start_flag) flag_cnt++;
        pg = grant;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_req(input int i, input logic [31:0] s, input logic [31:0] e,
                         input logic [1:0] m);
    sa[i*AW +: AW] = s;
    ea[i*AW +: AW] = e;
    md[i*2 +: 2]   = m;
  endtask

  task automatic issue(input int i);
    want_tok[i] = want_tok[i] + 1;
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    step();
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    step();
  endtask

  task automatic wait_idle(input string nm, input int budget);
    int n;
    n = 0;
    repeat (2) @(negedge clk);
    while (!(req == '0 && grant == '0 && exp_q.size() == 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) begin
      n_tests++;
      n_fail++;
      $display("[TB] FAIL %s: timed out, %0d events pending", nm, exp_q.size());
      exp_q.delete();
    end
    repeat (2) step();
  endtask

  task automatic wait_grant(input int i, input int budget);
    int n;
    n = 0;
    while (grant[i] !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) begin
      n_tests++;
      n_fail++;
      $display("[TB] FAIL wait_grant%0d: got no grant expected grant", i);
    end
    #1;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1);
  end

  // ---------------- directed tests ----------------
  initial begin
    int snap;
    for (int i = 0; i < N; i++) begin
      want_tok[i] = 0;
      rise_cyc[i] = 0;
      grant_cyc[i] = 0;
      done_cyc[i] = 0;
      err_cyc[i] = 0;
    end
    sa = '0;
    ea = '0;
    md = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_grant", grant, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_fault", fault, 0);
    check("rst_flag", eng_start_flag, 0);
    check("rst_saddr", eng_start_addr, 0);
    check("rst_eaddr", eng_end_addr, 0);
    check("rst_mode", eng_mode, 0);
    check("rst_state", dbg_state, ST_IDLE);
    step();
    rst = 1'b0;
    step();

    // T1: single quad read, 40-cycle engine
    set_req(0, 32'h100, 32'h10F, MODE_QUAD);
    eng_lat = 40;
    exp_q.push_back(ev(K_GRANT, 0));
    exp_q.push_back(ev(K_DONE, 0));
    issue(0);
    wait_grant(0, 10);
    check("t1_latency", grant_cyc[0] - rise_cyc[0], 1);
    check("t1_saddr", eng_start_addr, 32'h100);
    check("t1_eaddr", eng_end_addr, 32'h10F);
    check("t1_mode", eng_mode, 2);
    check("t1_state", dbg_state, ST_BUSY);
    wait_idle("t1", 200);
    check("t1_done_time", done_cyc[0] - grant_cyc[0], 40);

    // T2a: all three at once, pointer now 1 -> order 1, 2, 0
    set_req(1, 32'h1000, 32'h1FFF, MODE_SINGLE);
    set_req(2, 32'h2000, 32'h2003, MODE_DUAL);
    eng_lat = 5;
    exp_q.push_back(ev(K_GRANT, 1));
    exp_q.push_back(ev(K_DONE, 1));
    exp_q.push_back(ev(K_GRANT, 2));
    exp_q.push_back(ev(K_DONE, 2));
    exp_q.push_back(ev(K_GRANT, 0));
    exp_q.push_back(ev(K_DONE, 0));
    issue(0);
    issue(1);
    issue(2);
    wait_grant(2, 50);
    check("t2_saddr2", eng_start_addr, 32'h2000);
    check("t2_mode2", eng_mode, 1);
    wait_idle("t2a", 200);

    // T2b: from reset, req 0 and 2 -> order 0 then 2
    do_reset();
    exp_q.push_back(ev(K_GRANT, 0));
    exp_q.push_back(ev(K_DONE, 0));
    exp_q.push_back(ev(K_GRANT, 2));
    exp_q.push_back(ev(K_DONE, 2));
    issue(0);
    issue(2);
    wait_idle("t2b", 200);
    check("t2b_gap", grant_cyc[2] - done_cyc[0], 2);

    // T3: rejected requests never start the engine
    snap = flag_cnt;
    set_req(1, 32'h200, 32'h1FF, MODE_SINGLE);
    exp_q.push_back(ev(K_ERR, 1));
    issue(1);
    wait_idle("t3_order", 50);
    set_req(1, 32'h200, 32'h2FF, MODE_ILLEGAL);
    exp_q.push_back(ev(K_ERR, 1));
    issue(1);
    wait_idle("t3_mode3", 50);
    set_req(1, 32'h8000_0000, 32'h7FFF_FFFF, MODE_QUAD);
    exp_q.push_back(ev(K_ERR, 1));
    issue(1);
    wait_idle("t3_unsigned", 50);
    check("t3_no_flag", flag_cnt - snap, 0);
    check("t3_fault", fault, 0);
    // start == end is a legal one-byte read
    set_req(1, 32'h300, 32'h300, MODE_DUAL);
    eng_lat = 3;
    exp_q.push_back(ev(K_GRANT, 1));
    exp_q.push_back(ev(K_DONE, 1));
    issue(1);
    wait_idle("t3_equal", 50);

    // T4: engine never finishes -> timeout after 64 cycles, sticky fault
    do_reset();
    set_req(0, 32'h400, 32'h4FF, MODE_QUAD);
    eng_lat = -1;
    exp_q.push_back(ev(K_GRANT, 0));
    exp_q.push_back(ev(K_ERR, 0));
    issue(0);
    wait_idle("t4_timeout", 200);
    check("t4_err_time", err_cyc[0] - grant_cyc[0], 64);
    check("t4_fault", fault, 1);
    check("t4_state", dbg_state, ST_FAULT);
    check("t4_flag", eng_start_flag, 0);
    set_req(1, 32'h500, 32'h5FF, MODE_SINGLE);
    exp_q.push_back(ev(K_ERR, 1));
    issue(1);
    wait_idle("t4_req1", 50);
    check("t4_fault_held", fault, 1);
    set_req(2, 32'h600, 32'h6FF, MODE_SINGLE);
    exp_q.push_back(ev(K_ERR, 2));
    exp_q.push_back(ev(K_ERR, 0));
    issue(0);
    issue(2);
    wait_idle("t4_pair", 50);
    check("t4_err_spacing", err_cyc[0] - err_cyc[2], 2);
    do_reset();
    check("t4_fault_cleared", fault, 0);
    check("t4_state_idle", dbg_state, ST_IDLE);

    // T5: reset in the middle of a transfer
    set_req(0, 32'h700, 32'h7FF, MODE_QUAD);
    eng_lat = -1;
    exp_q.push_back(ev(K_GRANT, 0));
    issue(0);
    wait_grant(0, 10);
    repeat (5) step();
    rst = 1'b1;
    #1;
    check("t5_flag_async", eng_start_flag, 0);
    check("t5_grant_async", grant, 0);
    check("t5_saddr_async", eng_start_addr, 0);
    check("t5_state_async", dbg_state, ST_IDLE);
    repeat (3) step();
    rst = 1'b0;
    step();
    check("t5_queue_empty", exp_q.size(), 0);
    set_req(2, 32'h800, 32'h80F, MODE_SINGLE);
    eng_lat = 10;
    exp_q.push_back(ev(K_GRANT, 2));
    exp_q.push_back(ev(K_DONE, 2));
    issue(2);
    wait_grant(2, 10);
    check("t5_latency", grant_cyc[2] - rise_cyc[2], 1);
    check("t5_saddr", eng_start_addr, 32'h800);
    wait_idle("t5_after", 100);

    // T6: finish lands on the last timeout cycle -> finish wins
    set_req(0, 32'h900, 32'h9FF, MODE_SINGLE);
    eng_lat = 64;
    exp_q.push_back(ev(K_GRANT, 0));
    exp_q.push_back(ev(K_DONE, 0));
    issue(0);
    wait_idle("t6", 200);
    check("t6_done_time", done_cyc[0] - grant_cyc[0], 64);
    check("t6_fault", fault, 0);
    check("t6_state", dbg_state, ST_IDLE);

    repeat (3) step();
    check("final_queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
